// File: rtl/alu_result_demux.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_demux
// Desc     : Registered 1-to-LANES result demux. Each slot holds its word
//            until acked. Optional broadcast write: ALU_DEMUX_BROADCAST_EN.
// Revision : 1.0
// ============================================================================
module alu_result_demux #(
    parameter int WIDTH = 16,
    parameter int LANES = 16,
    parameter int SEL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
`ifdef ALU_DEMUX_BROADCAST_EN
    input  logic                   in_bcast,
`endif
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ack,
    output logic [7:0]             acc_cnt,
    output logic [7:0]             drop_cnt
);

    localparam int         c_SEL_SPAN = 1 << SEL_W;
    localparam logic [7:0] c_CNT_MAX  = 8'hFF;

    logic [c_SEL_SPAN-1:0] w_free;
    logic [LANES-1:0]      w_wr;
    logic                  w_bcast;
    logic                  w_sel_ok;
    logic                  w_accept;
    logic                  w_route;
    logic                  w_drop;
    logic [7:0]            r_acc;
    logic [7:0]            r_drop;

`ifdef ALU_DEMUX_BROADCAST_EN
    assign w_bcast = in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // Selects past the last lane read as "free" so a discard is never stalled.
    generate
        for (genvar gi = 0; gi < c_SEL_SPAN; gi++) begin : g_free
            if (gi < LANES) begin : g_lane
                assign w_free[gi] = ~out_valid[gi] | out_ack[gi];
            end else begin : g_oor
                assign w_free[gi] = 1'b1;
            end
        end
    endgenerate

    assign w_sel_ok = (32'(in_sel) < LANES);
    assign in_ready = w_bcast ? (&w_free) : w_free[in_sel];
    assign w_accept = in_valid & in_ready;
    assign w_route  = w_accept & (w_bcast | w_sel_ok);
    assign w_drop   = w_accept & ~w_bcast & ~w_sel_ok;

    generate
        for (genvar gk = 0; gk < LANES; gk++) begin : g_slot
            logic [WIDTH-1:0] r_word;
            logic             r_full;

            assign w_wr[gk] = w_accept & (w_bcast | (w_sel_ok & (in_sel == SEL_W'(gk))));

            // A write wins over an ack in the same cycle, so the slot stays full.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_word <= '0;
                    r_full <= 1'b0;
                end else if (w_wr[gk]) begin
                    r_word <= in_data;
                    r_full <= 1'b1;
                end else if (out_ack[gk]) begin
                    r_full <= 1'b0;
                end
            end

            assign out_data[gk*WIDTH +: WIDTH] = r_word;
            assign out_valid[gk]               = r_full;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= 8'd0;
            r_drop <= 8'd0;
        end else begin
            if (w_route) begin
                r_acc <= r_acc + 8'd1;
            end
            if (w_drop && (r_drop != c_CNT_MAX)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign acc_cnt  = r_acc;
    assign drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_demux
// Desc     : Self-checking bench for alu_result_demux (LANES=16 and LANES=8
//            instances share stimulus); honours ALU_DEMUX_BROADCAST_EN.
// Revision : 1.0
// ============================================================================
module tb_alu_result_demux;

    localparam int LA = 16;
    localparam int LB = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic [15:0]  in_data  = '0;
    logic [3:0]   in_sel   = '0;
    logic [15:0]  in_ack   = '0;
    logic         bcast    = 1'b0;

    logic         ready_a, ready_b;
    logic [255:0] data_a;
    logic [127:0] data_b;
    logic [15:0]  valid_a;
    logic [7:0]   valid_b;
    logic [7:0]   acc_a, drop_a, acc_b, drop_b;

    always #5 clk = ~clk;

    alu_result_demux #(.WIDTH(16), .LANES(LA), .SEL_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_a),
        .in_data(in_data), .in_sel(in_sel),
`ifdef ALU_DEMUX_BROADCAST_EN
        .in_bcast(bcast),
`endif
        .out_data(data_a), .out_valid(valid_a), .out_ack(in_ack),
        .acc_cnt(acc_a), .drop_cnt(drop_a)
    );

    alu_result_demux #(.WIDTH(16), .LANES(LB), .SEL_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_b),
        .in_data(in_data), .in_sel(in_sel),
`ifdef ALU_DEMUX_BROADCAST_EN
        .in_bcast(bcast),
`endif
        .out_data(data_b), .out_valid(valid_b), .out_ack(in_ack[7:0]),
        .acc_cnt(acc_b), .drop_cnt(drop_b)
    );

    // Reference model: per-instance slot contents, full flags and counters.
    logic [15:0] m_data [2][16];
    logic        m_valid[2][16];
    int          m_acc  [2];
    int          m_drop [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int lanes_of(input int i);
        return (i == 0) ? LA : LB;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) begin
                m_data[i][k]  = '0;
                m_valid[i][k] = 1'b0;
            end
            m_acc[i]  = 0;
            m_drop[i] = 0;
        end
    endtask

    function automatic logic model_ready(input int i);
        int   n        = lanes_of(i);
        logic all_free = 1'b1;
        for (int k = 0; k < n; k++)
            if (m_valid[i][k] && !in_ack[k]) all_free = 1'b0;
        if (bcast) return all_free;
        if (int'(in_sel) >= n) return 1'b1;
        return !m_valid[i][in_sel] || in_ack[in_sel];
    endfunction

    task automatic model_step(input int i);
        int   n   = lanes_of(i);
        logic acc = in_valid && model_ready(i);
        for (int k = 0; k < n; k++) begin
            if (acc && (bcast || int'(in_sel) == k)) begin
                m_data[i][k]  = in_data;
                m_valid[i][k] = 1'b1;
            end else if (in_ack[k]) begin
                m_valid[i][k] = 1'b0;
            end
        end
        if (acc && (bcast || int'(in_sel) < n)) m_acc[i] = (m_acc[i] + 1) % 256;
        else if (acc) m_drop[i] = (m_drop[i] < 255) ? m_drop[i] + 1 : 255;
    endtask

    function automatic logic [255:0] exp_data(input int i);
        logic [255:0] v = '0;
        for (int k = 0; k < lanes_of(i); k++) v[k*16 +: 16] = m_data[i][k];
        return v;
    endfunction

    function automatic logic [255:0] exp_valid(input int i);
        logic [255:0] v = '0;
        for (int k = 0; k < lanes_of(i); k++) v[k] = m_valid[i][k];
        return v;
    endfunction

    // Compare on the falling edge: state is settled and inputs are stable.
    initial forever begin
        @(negedge clk);
        if (!rst_n) model_reset();
        chk("a_data",  data_a,  exp_data(0));
        chk("a_valid", valid_a, exp_valid(0));
        chk("a_acc",   acc_a,   256'(m_acc[0]));
        chk("a_drop",  drop_a,  256'(m_drop[0]));
        chk("a_ready", ready_a, model_ready(0));
        chk("b_data",  data_b,  exp_data(1));
        chk("b_valid", valid_b, exp_valid(1));
        chk("b_acc",   acc_b,   256'(m_acc[1]));
        chk("b_drop",  drop_b,  256'(m_drop[1]));
        chk("b_ready", ready_b, model_ready(1));
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic drive(input logic v, input logic [3:0] s, input logic [15:0] d, input logic [15:0] a);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        in_ack   = a;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 16'h0000, 16'h0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;

        // Reset mid-stream with slots 3 and 7 full
        drive(1'b1, 4'd3, 16'h1111, 16'h0000); tick();
        drive(1'b1, 4'd7, 16'h2222, 16'h0000); tick();
        idle();
        chk("pre_rst_valid", valid_a, 256'h0088);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", valid_a, 256'h0);
        chk("rst_data",  data_a,  256'h0);
        chk("rst_acc",   acc_a,   256'h0);
        chk("rst_drop",  drop_a,  256'h0);
        chk("rst_ready", ready_a, 256'h1);
        tick();
        rst_n = 1'b1;

        // Single route and ack
        drive(1'b1, 4'd5, 16'hAAAA, 16'h0000); tick(); idle();
        chk("route_valid", valid_a, 256'h0020);
        chk("route_data",  data_a[80 +: 16], 256'hAAAA);
        chk("route_acc",   acc_a, 256'h1);
        drive(1'b0, 4'd0, 16'h0000, 16'h0020); tick(); idle();
        chk("ack_valid", valid_a, 256'h0);
        chk("ack_data",  data_a[80 +: 16], 256'hAAAA);

        // Back-pressure, then ack and write together
        drive(1'b1, 4'd2, 16'h1234, 16'h0000); tick();
        drive(1'b1, 4'd2, 16'h5678, 16'h0000);
        chk("bp_ready", ready_a, 256'h0);
        tick();
        chk("bp_hold_data",  data_a[32 +: 16], 256'h1234);
        chk("bp_hold_valid", valid_a[2], 256'h1);
        drive(1'b1, 4'd2, 16'h5678, 16'h0004);
        chk("bp_ack_ready", ready_a, 256'h1);
        tick(); idle();
        chk("bp_new_data",  data_a[32 +: 16], 256'h5678);
        chk("bp_new_valid", valid_a[2], 256'h1);

        // Sweep all selects
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 4'(k), 16'(16'hF000 + k), 16'h0000);
            tick();
        end
        idle();
        chk("sweep_valid", valid_a, 256'hFFFF);
        for (int k = 0; k < 16; k++)
            chk("sweep_data", data_a[k*16 +: 16], 256'(16'hF000 + k));
        chk("sweep_acc",    acc_a,   256'd16);
        chk("sweep_b_val",  valid_b, 256'hFF);
        chk("sweep_b_acc",  acc_b,   256'd8);
        chk("sweep_b_drop", drop_b,  256'd8);

        // Out-of-range select on the 8-lane instance; wrap/saturate counters
        do_reset();
        drive(1'b1, 4'd12, 16'hFACE, 16'h1000);
        chk("oor_ready", ready_b, 256'h1);
        tick(); idle();
        chk("oor_valid", valid_b, 256'h0);
        chk("oor_data",  data_b,  256'h0);
        chk("oor_drop",  drop_b,  256'd1);
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, 4'd12, 16'hFACE, 16'h1000);
            tick();
        end
        idle();
        chk("sat_drop_b", drop_b, 256'd255);
        chk("wrap_acc_a", acc_a,  256'd45);
        chk("oor_drop_a", drop_a, 256'd0);

`ifdef ALU_DEMUX_BROADCAST_EN
        do_reset();
        bcast = 1'b1;
        drive(1'b1, 4'd0, 16'h0F0F, 16'h0000); tick();
        bcast = 1'b0;
        idle();
        chk("bc_valid", valid_a, 256'hFFFF);
        chk("bc_data",  data_a,  {16{16'h0F0F}});
        chk("bc_acc",   acc_a,   256'd1);
        chk("bc_b_val", valid_b, 256'hFF);
        bcast = 1'b1;
        drive(1'b1, 4'd0, 16'h1111, 16'hFDFF);
        chk("bc_block_ready", ready_a, 256'h0);
        chk("bc_b_ready",     ready_b, 256'h1);
        tick();
        bcast = 1'b0;
        idle();
`endif

        // Randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
`ifdef ALU_DEMUX_BROADCAST_EN
            bcast = ($urandom_range(0, 15) == 0);
`endif
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  16'($urandom), 16'($urandom & $urandom));
            tick();
        end
        rst_n = 1'b1;
        bcast = 1'b0;
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_demux.md
# alu_result_demux

Registered 1-to-LANES demultiplexer that routes the 16-bit ALU result to one of LANES destination slots. It inverts the 16:1 result-selection muxes: where those pick one of many sources, this block steers one source to many sinks. Each slot holds its word until the consumer acknowledges it, which back-pressures the ALU side through a valid/ready handshake. The block sits between the ALU output stage and the destination register/consumer logic.

## Interface
- `WIDTH`, 16, data width of every word.
- `LANES`, 16, number of destination slots, range 2..16.
- `SEL_W`, 4, select width; fixed at 4 so that out-of-range selects are representable.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  source presents a word.
- `in_ready`  out  1  block accepts the word this cycle (combinational).
- `in_data`  in  WIDTH  word to route.
- `in_sel`  in  SEL_W  destination slot index.
- `out_data`  out  LANES*WIDTH  flattened slot registers; slot k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  out  LANES  slot k holds an unconsumed word.
- `out_ack`  in  LANES  consumer of slot k takes the word.
- `acc_cnt`  out  8  words accepted into slots, wraps at 255→0.
- `drop_cnt`  out  8  words discarded because of an out-of-range select, saturates at 255.

## Operation
- Each slot has two states, EMPTY (`out_valid[k]`=0) and FULL (`out_valid[k]`=1).
- Accept condition: `in_valid & in_ready` at a rising edge.
- `in_ready`:
  - For `in_sel < LANES`: `!out_valid[in_sel] | out_ack[in_sel]`.
  - For `in_sel >= LANES`: 1.
  - `in_ready` does not depend on `in_valid`.
- Accept with `in_sel < LANES`:
  - Slot `in_sel` loads `in_data` and goes to FULL.
  - `acc_cnt` increments.
- Accept with `in_sel >= LANES`:
  - The word is discarded and no slot changes.
  - `drop_cnt` increments, saturating at 255.
- Ack: `out_ack[k]` while slot k is FULL returns the slot to EMPTY, unless a word is written to slot k in the same cycle.
  - `out_data` keeps its last value after ack; only `out_valid` clears.
  - Ack on an EMPTY slot is ignored.
- Simultaneous ack and write to the same slot: the slot stays FULL with the new data. No cycle is lost.
- Acks to other slots in the same cycle as a write are processed independently.
- Reset (any time, including mid-transfer):
  - All `out_valid` = 0, all `out_data` = 0, `acc_cnt` = 0, `drop_cnt` = 0.
  - Pending words are lost.
  - `in_ready` = 1 while in reset and immediately after, because all slots are EMPTY.

## Timing
- Latency: a word accepted at edge N appears on `out_data`/`out_valid` after edge N (visible in cycle N+1).
- Throughput: one word per cycle to distinct slots, or to the same slot if the slot is acked every cycle.
- The `out_ack[in_sel]` → `in_ready` path is combinational. The source must not make `in_valid` depend on `in_ready`.
- `acc_cnt` and `drop_cnt` update on the same edge as the accept.

## Configuration
- Macro: `ALU_DEMUX_BROADCAST_EN`.
- Defined:
  - Adds port `in_bcast  in  1`.
  - An accept with `in_bcast`=1 writes `in_data` to every slot, ignoring `in_sel`.
  - `in_ready` = AND over k of (`!out_valid[k] | out_ack[k]`).
  - `acc_cnt` increments by 1.
  - `drop_cnt` is unaffected.
- Undefined:
  - The port is absent.
  - Behaviour is exactly as in Operation.

## Test plan
- **Reset state:** assert `rst_n`=0 mid-stream with slots 3 and 7 FULL → all `out_valid`=0, `out_data`=0, counters=0, `in_ready`=1.
- **Single route:** `in_data`=16'hAAAA, `in_sel`=5, one cycle → next cycle `out_valid`=16'h0020, slot 5=16'hAAAA, `acc_cnt`=1. Ack slot 5 → `out_valid`=0, slot 5 data still 16'hAAAA.
- **Back-pressure:** slot 2 FULL with 16'h1234, no ack, send 16'h5678 to slot 2 → `in_ready`=0, slot 2 unchanged. Raise `out_ack[2]` → accepted that cycle, slot 2=16'h5678, still FULL.
- **Sweep:** write 16'hF000+k to slots 0..15 on consecutive cycles → all 16 `out_valid` bits set, each slot holds its value, `acc_cnt`=16.
- **Out-of-range select:** `LANES`=8, `in_sel`=12, `in_data`=16'hFACE → `in_ready`=1, no slot changes, `drop_cnt`=1. Then 300 more such writes → `drop_cnt`=255.
- **Broadcast (with `ALU_DEMUX_BROADCAST_EN` defined):** `in_bcast`=1, `in_data`=16'h0F0F, all slots EMPTY → all slots=16'h0F0F, `out_valid` all ones. Repeat with slot 9 FULL and not acked → `in_ready`=0.
